bus_master: RTL

Single-outstanding bus master that turns CPU-side load/store requests into the shared-bus valid/ready protocol spoken by the address-decoded bus slaves. It sits directly upstream of the slaves: drives `BUS_addr`, `BUS_wdata`, `BUS_mode`, `BUS_valid` and `BUS_rready`, and consumes `BUS_wready`, `BUS_rvalid` and `BUS_rdata`. A watchdog terminates transfers that no slave answers, for example an unmapped address, and returns an error response.

---
 rtl/bus_master.sv | 125 ++++++++++++
 1 files changed

// File: rtl/bus_master.sv
// Single-outstanding CPU-to-bus master with valid/ready handshake and a timeout watchdog.
// States: S_IDLE | waiting for a CPU request; S_WRITE | store in flight; S_READ | load in flight.
module bus_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic                  resp_err,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic [ADDR_WIDTH-1:0] BUS_addr,
  output logic [DATA_WIDTH-1:0] BUS_wdata,
  output logic                  BUS_mode,
  output logic                  BUS_valid,
  input  logic                  BUS_wready,
  input  logic                  BUS_rvalid,
  input  logic [DATA_WIDTH-1:0] BUS_rdata,
  output logic                  BUS_rready
);

  // A zero-width counter is illegal, so a disabled watchdog keeps one unused bit.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ} state_t;

  state_t                  r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic                    r_mode;
  logic                    r_valid;
  logic                    r_resp_valid;
  logic                    r_resp_err;
  logic [DATA_WIDTH-1:0]   r_resp_rdata;

  logic w_accept;
  logic w_expire;

  assign req_ready  = (r_state == S_IDLE) && !rst;
  assign BUS_rready = (r_state == S_READ) && BUS_rvalid;
  assign w_accept   = req_valid && req_ready;
  assign w_expire   = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT - 1));

  assign BUS_addr   = r_addr;
  assign BUS_wdata  = r_wdata;
  assign BUS_mode   = r_mode;
  assign BUS_valid  = r_valid;
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_mode       <= 1'b0;
      r_valid      <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_mode  <= req_write;
            r_valid <= 1'b1;
            r_cnt   <= '0;
            r_state <= req_write ? S_WRITE : S_READ;
          end
        end
        S_WRITE: begin
          // A handshake in the expiry cycle takes priority over the timeout.
          if (BUS_wready) begin
            r_valid      <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_rdata <= '0;
            r_state      <= S_IDLE;
          end else if (w_expire) begin
            r_valid      <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b1;
            r_resp_rdata <= '0;
            r_state      <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_READ: begin
          if (BUS_rvalid) begin
            r_valid      <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_rdata <= BUS_rdata;
            r_state      <= S_IDLE;
          end else if (w_expire) begin
            r_valid      <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b1;
            r_resp_rdata <= '0;
            r_state      <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
